// File: rtl/telemetry_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : telemetry_monitor
//  Description : UART receiver plus AA/55-framed packet decoder recovering the
//                battery, current and torque samples from the eBike TX line.
//  Revision    : 1.0 - initial release
// ============================================================================
module telemetry_monitor #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_tx,
  output logic [11:0] curr_tx,
  output logic [11:0] torque_tx,
  output logic        vld_tx,
  output logic        frm_err,
  output logic        pkt_err,
  output logic [7:0]  pkt_cnt
);

  localparam int                 c_cnt_w = $clog2(BAUD_DIV);
  localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(BAUD_DIV / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(BAUD_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  typedef enum logic [1:0] {
    P_HUNT_AA = 2'd0,
    P_HUNT_55 = 2'd1,
    P_PAYLOAD = 2'd2
  } pkt_state_t;

  logic r_rx_meta, r_rx_s, r_rx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  logic w_fall;
  assign w_fall = r_rx_d & ~r_rx_s;

  uart_state_t        r_ustate, w_ustate_nxt;
  logic [c_cnt_w-1:0] r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_byte_rdy;
  logic               w_tick, w_load_half, w_load_full, w_shift, w_byte_ok, w_byte_bad;

  assign w_tick = (r_baud == '0);

  always_comb begin
    w_ustate_nxt = r_ustate;
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_shift      = 1'b0;
    w_byte_ok    = 1'b0;
    w_byte_bad   = 1'b0;
    case (r_ustate)
      U_IDLE: begin
        if (w_fall) begin
          w_load_half  = 1'b1;
          w_ustate_nxt = U_START;
        end
      end
      U_START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_ustate_nxt = U_IDLE;
          end else begin
            w_load_full  = 1'b1;
            w_ustate_nxt = U_DATA;
          end
        end
      end
      U_DATA: begin
        if (w_tick) begin
          w_shift     = 1'b1;
          w_load_full = 1'b1;
          if (r_bit == 3'd7) w_ustate_nxt = U_STOP;
        end
      end
      U_STOP: begin
        if (w_tick) begin
          w_ustate_nxt = U_IDLE;
          w_byte_ok    = r_rx_s;
          w_byte_bad   = ~r_rx_s;
        end
      end
      default: w_ustate_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ustate <= U_IDLE;
    else        r_ustate <= w_ustate_nxt;
  end

  // The received byte stays parked in r_shift until the next start bit is confirmed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud     <= '0;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_byte_rdy <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      if (w_load_half)      r_baud <= c_half;
      else if (w_load_full) r_baud <= c_full;
      else if (!w_tick)     r_baud <= r_baud - c_one;

      if (r_ustate == U_START) r_bit <= 3'd0;
      else if (w_shift)        r_bit <= r_bit + 3'd1;

      if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};

      r_byte_rdy <= w_byte_ok;
      frm_err    <= w_byte_bad;
    end
  end

  pkt_state_t r_pstate, w_pstate_nxt;
  logic [2:0]  r_idx;
  logic        r_bad;
  logic [11:0] r_sh_batt, r_sh_curr;
  logic [3:0]  r_sh_torq_hi;
  logic        w_hi_bad, w_commit, w_reject;

  assign w_hi_bad = ~r_idx[0] & (r_shift[7:4] != 4'h0);

  always_comb begin
    w_pstate_nxt = r_pstate;
    w_commit     = 1'b0;
    w_reject     = 1'b0;
    if (frm_err) begin
      w_pstate_nxt = P_HUNT_AA;
    end else if (r_byte_rdy) begin
      case (r_pstate)
        P_HUNT_AA: if (r_shift == 8'hAA) w_pstate_nxt = P_HUNT_55;
        P_HUNT_55: begin
          if (r_shift == 8'h55)      w_pstate_nxt = P_PAYLOAD;
          else if (r_shift != 8'hAA) w_pstate_nxt = P_HUNT_AA;
        end
        P_PAYLOAD: begin
          if (r_idx == 3'd5) begin
            w_pstate_nxt = P_HUNT_AA;
            w_reject     = r_bad;
            w_commit     = ~r_bad;
          end
        end
        default: w_pstate_nxt = P_HUNT_AA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pstate <= P_HUNT_AA;
    else        r_pstate <= w_pstate_nxt;
  end

  // The final torque low byte bypasses the shadow and lands directly in the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 3'd0;
      r_bad        <= 1'b0;
      r_sh_batt    <= 12'd0;
      r_sh_curr    <= 12'd0;
      r_sh_torq_hi <= 4'd0;
      batt_tx      <= 12'd0;
      curr_tx      <= 12'd0;
      torque_tx    <= 12'd0;
      vld_tx       <= 1'b0;
      pkt_err      <= 1'b0;
      pkt_cnt      <= 8'd0;
    end else begin
      vld_tx  <= w_commit;
      pkt_err <= w_reject;
      if (r_byte_rdy && (r_pstate == P_HUNT_55) && (r_shift == 8'h55)) begin
        r_idx <= 3'd0;
        r_bad <= 1'b0;
      end else if (r_byte_rdy && (r_pstate == P_PAYLOAD)) begin
        r_idx <= r_idx + 3'd1;
        if (w_hi_bad) r_bad <= 1'b1;
        case (r_idx)
          3'd0:    r_sh_batt[11:8] <= r_shift[3:0];
          3'd1:    r_sh_batt[7:0]  <= r_shift;
          3'd2:    r_sh_curr[11:8] <= r_shift[3:0];
          3'd3:    r_sh_curr[7:0]  <= r_shift;
          3'd4:    r_sh_torq_hi    <= r_shift[3:0];
          default: ;
        endcase
      end
      if (w_commit) begin
        batt_tx   <= r_sh_batt;
        curr_tx   <= r_sh_curr;
        torque_tx <= {r_sh_torq_hi, r_shift};
        pkt_cnt   <= pkt_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_telemetry_monitor.sv
`default_nettype none
// Directed bench for telemetry_monitor: a 4-clock bit period keeps the 256-packet wrap run short.
module tb_telemetry_monitor;

  localparam int BAUD  = 4;
  localparam int CLK_P = 100;

  logic        clk, rst_n, RX;
  logic [11:0] batt_tx, curr_tx, torque_tx;
  logic        vld_tx, frm_err, pkt_err;
  logic [7:0]  pkt_cnt;

  telemetry_monitor #(.BAUD_DIV(BAUD)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .batt_tx   (batt_tx),
    .curr_tx   (curr_tx),
    .torque_tx (torque_tx),
    .vld_tx    (vld_tx),
    .frm_err   (frm_err),
    .pkt_err   (pkt_err),
    .pkt_cnt   (pkt_cnt)
  );

  always #(CLK_P / 2) clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
    logic [7:0]  n;
  } ev_t;

  ev_t         q[$];
  ev_t         e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_good  = 0;
  int          n_vld_cycles = 0;
  int          bit_len = BAUD * CLK_P;
  logic [11:0] m_batt = 12'd0, m_curr = 12'd0, m_torq = 12'd0;
  logic [7:0]  m_cnt  = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (vld_tx || frm_err || pkt_err)) begin
      if (vld_tx) n_vld_cycles++;
      if (q.size() == 0) begin
        chk("unexpected_event", {29'd0, vld_tx, frm_err, pkt_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("event_kind", {29'd0, vld_tx, frm_err, pkt_err}, {29'd0, e.kind});
        chk("batt_tx",   {20'd0, batt_tx},   {20'd0, e.b});
        chk("curr_tx",   {20'd0, curr_tx},   {20'd0, e.c});
        chk("torque_tx", {20'd0, torque_tx}, {20'd0, e.t});
        chk("pkt_cnt",   {24'd0, pkt_cnt},   {24'd0, e.n});
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    #(bit_len);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      #(bit_len);
    end
    RX = stop;
    #(bit_len);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic idle(input int nbits);
    RX = 1'b1;
    #(nbits * bit_len);
  endtask

  task automatic expect_vld(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    m_batt = b;
    m_curr = c;
    m_torq = t;
    m_cnt  = m_cnt + 8'd1;
    n_good++;
    q.push_back('{3'b100, b, c, t, m_cnt});
  endtask

  task automatic expect_err(input logic [2:0] kind);
    q.push_back('{kind, m_batt, m_curr, m_torq, m_cnt});
  endtask

  task automatic send_payload(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    send_byte({4'h0, b[11:8]}); send_byte(b[7:0]);
    send_byte({4'h0, c[11:8]}); send_byte(c[7:0]);
    send_byte({4'h0, t[11:8]}); send_byte(t[7:0]);
  endtask

  task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    expect_vld(b, c, t);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_payload(b, c, t);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_batt"},   {20'd0, batt_tx},   32'd0);
    chk({tag, "_curr"},   {20'd0, curr_tx},   32'd0);
    chk({tag, "_torque"}, {20'd0, torque_tx}, 32'd0);
    chk({tag, "_cnt"},    {24'd0, pkt_cnt},   32'd0);
    chk({tag, "_vld"},    {31'd0, vld_tx},    32'd0);
    chk({tag, "_frm"},    {31'd0, frm_err},   32'd0);
    chk({tag, "_pkt"},    {31'd0, pkt_err},   32'd0);
  endtask

  initial begin
    logic [11:0] wb, wc, wt;
    clk   = 1'b0;
    rst_n = 1'b0;
    RX    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #(CLK_P / 4);
    rst_n = 1'b1;
    idle(4);

    // Good packet, back-to-back bytes
    expect_vld(12'hAC0, 12'h123, 12'h700);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A); send_byte(8'hC0);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h07); send_byte(8'h00);
    drain(200);
    chk("good_cnt", {24'd0, pkt_cnt}, 32'd1);

    // Resync through junk and a repeated AA
    expect_vld(12'hFFF, 12'h000, 12'h500);
    send_byte(8'h13); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_payload(12'hFFF, 12'h000, 12'h500);
    drain(200);

    // Framing error on the 4th byte, then a clean packet
    expect_err(3'b010);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    send_frame(8'hC0, 1'b0);
    idle(3);
    drain(200);
    send_pkt(12'h102, 12'h304, 12'h506);
    drain(200);

    // Format error in the battery high byte
    expect_err(3'b001);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1A);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    drain(200);
    chk("fmt_cnt_hold", {24'd0, pkt_cnt}, 32'd3);

    // Sub-half-bit glitch between AA and 55 must not disturb the header hunt
    send_byte(8'hAA);
    idle(2);
    RX = 1'b0;
    #(CLK_P);
    idle(12);
    chk("glitch_quiet", q.size(), 32'd0);
    expect_vld(12'h0DE, 12'h0AD, 12'hBEE);
    send_byte(8'h55);
    send_payload(12'h0DE, 12'h0AD, 12'hBEE);
    drain(200);

    // Reset in the middle of a payload byte
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    RX = 1'b0;
    #(6 * CLK_P);
    rst_n = 1'b0;
    #(2 * CLK_P);
    @(negedge clk);
    chk_all_zero("midreset");
    RX = 1'b1;
    @(posedge clk);
    #(CLK_P / 4);
    rst_n  = 1'b1;
    m_batt = 12'd0; m_curr = 12'd0; m_torq = 12'd0; m_cnt = 8'd0;
    idle(4);
    send_pkt(12'hAC0, 12'h123, 12'h700);
    drain(200);

    // +/-2 % bit-time error
    bit_len = BAUD * CLK_P * 98 / 100;
    send_pkt(12'h321, 12'h654, 12'h0AB);
    bit_len = BAUD * CLK_P * 102 / 100;
    send_pkt(12'h9F0, 12'h00F, 12'hE01);
    drain(200);
    bit_len = BAUD * CLK_P;
    idle(2);

    // Counter wrap: 253 more good packets reach 256 since reset
    for (int i = 0; i < 253; i++) begin
      wb = 12'(i * 37);
      wc = 12'(i * 113 + 5);
      wt = 12'(4095 - i);
      send_pkt(wb, wc, wt);
    end
    drain(400);
    chk("wrap_cnt", {24'd0, pkt_cnt}, 32'd0);
    chk("vld_cycles", n_vld_cycles, n_good);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
